// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory, data has priority.
// Define MEM_TIMEOUT_EN to abort transactions that see no MemAck within 15 busy cycles.
module mem_port_arbiter (
   input  logic        CLK,
   input  logic        reset,
   input  logic        IReqF,
   input  logic [31:0] IAddrF,
   output logic [31:0] IRdataF,
   output logic        IReadyF,
   input  logic        DReqM,
   input  logic        DWeM,
   input  logic [31:0] DAddrM,
   input  logic [31:0] DWdataM,
   output logic [31:0] DRdataM,
   output logic        DReadyM,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWdata,
   input  logic [31:0] MemRdata,
   input  logic        MemAck,
   output logic        StallIF,
   output logic        StallMEM,
   output logic        ErrTimeout
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   state_t state, stateNext;
   logic   grantD, grantI, done, timeoutHit;

`ifdef MEM_TIMEOUT_EN
   logic [3:0] busyCnt;

   // busyCnt counts finished busy cycles; abort as the 15th one ends without an ack
   assign timeoutHit = (state != IDLE) && !MemAck && (busyCnt == 4'd14);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         busyCnt    <= 4'd0;
         ErrTimeout <= 1'b0;
      end else begin
         if (grantD || grantI)
            busyCnt <= 4'd0;
         else if (state != IDLE && !done)
            busyCnt <= busyCnt + 4'd1;
         if (timeoutHit)
            ErrTimeout <= 1'b1;
      end
   end
`else
   assign timeoutHit = 1'b0;
   assign ErrTimeout = 1'b0;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // A requester whose ready pulse is showing is skipped so it cannot be re-granted
   always_comb begin
      stateNext = state;
      grantD    = 1'b0;
      grantI    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (DReqM && !DReadyM) begin
               grantD    = 1'b1;
               stateNext = DBUSY;
            end else if (IReqF && !IReadyF) begin
               grantI    = 1'b1;
               stateNext = IBUSY;
            end
         end
         IBUSY, DBUSY: begin
            if (MemAck || timeoutHit) begin
               done      = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         MemAddr  <= 32'h0;
         MemWdata <= 32'h0;
         MemWe    <= 1'b0;
         IRdataF  <= 32'h0;
         DRdataM  <= 32'h0;
         IReadyF  <= 1'b0;
         DReadyM  <= 1'b0;
      end else begin
         IReadyF <= 1'b0;
         DReadyM <= 1'b0;
         if (grantD) begin
            MemAddr  <= DAddrM;
            MemWdata <= DWdataM;
            MemWe    <= DWeM;
         end else if (grantI) begin
            MemAddr  <= IAddrF;
            MemWdata <= 32'h0;
            MemWe    <= 1'b0;
         end else if (done) begin
            MemWdata <= 32'h0;
            MemWe    <= 1'b0;
         end
         if (done) begin
            if (state == IBUSY) begin
               IReadyF <= 1'b1;
               IRdataF <= timeoutHit ? 32'h0 : MemRdata;
            end else begin
               DReadyM <= 1'b1;
               if (timeoutHit)
                  DRdataM <= 32'h0;
               else if (!MemWe)
                  DRdataM <= MemRdata;
            end
         end
      end
   end

   assign MemReq   = (state != IDLE);
   assign StallIF  = IReqF & ~IReadyF;
   assign StallMEM = DReqM & ~DReadyM;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have CLK, input, 1: the single clock; all state changes on posedge CLK.
REQ-002 SHALL have reset, input, 1: asynchronous, active-high; clears all state immediately, independent of CLK.
REQ-003 SHALL have IReqF, input, 1: instruction-fetch request; held until IReadyF.
REQ-004 SHALL have IAddrF, input, 32: fetch word address.
REQ-005 SHALL have IRdataF, output, 32: fetched instruction, registered.
REQ-006 SHALL have IReadyF, output, 1: one-cycle pulse, IRdataF valid.
REQ-007 SHALL have DReqM, DWeM, input, 1 each: data request and write enable (1 = store, 0 = load).
REQ-008 SHALL have DAddrM, DWdataM, input, 32 each: data address and store data.
REQ-009 SHALL have DRdataM, output, 32: load data, registered.
REQ-010 SHALL have DReadyM, output, 1: one-cycle completion pulse for a load or store.
REQ-011 SHALL have MemReq, MemWe, output, 1 each: request and write enable to the single-port memory.
REQ-012 SHALL have MemAddr, MemWdata, output, 32 each: latched address and write data.
REQ-013 SHALL have MemRdata, input, 32, and MemAck, input, 1: memory read data and completion (latency 1..N cycles).
REQ-014 SHALL have StallIF and StallMEM, output, 1 each: IReqF & ~IReadyF and DReqM & ~DReadyM, combinational, for the hazard unit.
REQ-015 SHALL have ErrTimeout, output, 1: sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, IBUSY and DBUSY.
REQ-017 SHALL, in IDLE, grant DReqM before IReqF when both are high; a data grant goes to DBUSY, an instruction grant goes to IBUSY.
REQ-018 SHALL, on grant, latch address, write data and write enable into MemAddr, MemWdata and MemWe; in IDLE, MemWe and MemWdata hold 0.
REQ-019 SHALL drive MemReq = 1 exactly while the state is IBUSY or DBUSY; the latched values stay stable until MemAck.
REQ-020 SHALL, in IBUSY or DBUSY with MemAck = 1, capture MemRdata into IRdataF or DRdataM, pulse IReadyF or DReadyM high in the next cycle, and return to IDLE.
REQ-021 SHALL leave DRdataM unchanged on a store completion.
REQ-022 SHALL NOT grant a requester during the IDLE cycle in which that requester's ready pulse is high; this blocks a re-grant of the completing request.
REQ-023 SHALL grant the other pending requester in that same IDLE cycle; minimum turnaround is 1 idle cycle between transactions.
REQ-024 SHALL ignore request changes while BUSY; DReqM/IReqF deassertion mid-transaction does not abort it.
REQ-025 SHALL ignore MemAck while in IDLE.
REQ-026 SHALL hold IRdataF and DRdataM until overwritten by the next completion of the same type.

Reset
REQ-027 SHALL, on reset assertion, immediately force: state IDLE; MemReq, MemWe, IReadyF, DReadyM and ErrTimeout 0; MemAddr, MemWdata, IRdataF and DRdataM 0x00000000.
REQ-028 SHALL, on reset mid-transaction, drop the transaction with no ready pulse; a MemAck arriving after release is ignored per REQ-025.
REQ-029 SHALL make its first grant possible no earlier than the first posedge CLK after reset deasserts.

Configuration
REQ-030 SHALL, with MEM_TIMEOUT_EN defined, include a 4-bit busy-cycle counter cleared on every grant.
REQ-031 SHALL, with MEM_TIMEOUT_EN defined, abort when the counter reaches 15 with no MemAck: return to IDLE, pulse the owner's ready with its read data register loaded with 0x00000000, and set ErrTimeout; ErrTimeout clears only on reset.
REQ-032 SHALL, without MEM_TIMEOUT_EN, wait for MemAck indefinitely, omit the counter, and tie ErrTimeout to 0.

Verification
REQ-033 SHALL pass: IReqF = 1, IAddrF = 0x40, MemAck one cycle after MemReq, MemRdata = 0x20080005 -> IReadyF pulses once, IRdataF = 0x20080005, MemWe = 0.
REQ-034 SHALL pass: IReqF and DReqM both rise together, load from 0x100 -> data served first, MemAddr = 0x100, then 0x40 granted in the IDLE cycle of DReadyM.
REQ-035 SHALL pass: store DWeM = 1, DAddrM = 0x8, DWdataM = 0xDEADBEEF, MemAck after 3 cycles -> MemWe = 1 with stable address and data for 3 cycles, DReadyM pulses, DRdataM unchanged.
REQ-036 SHALL pass: reset asserted while in DBUSY -> MemReq drops in the same cycle without a clock edge, no DReadyM pulse, all outputs 0.
REQ-037 SHALL pass, with MEM_TIMEOUT_EN: MemAck held 0 -> abort after 15 busy cycles, DReadyM pulses, DRdataM = 0, ErrTimeout = 1 until reset; without the macro, MemReq is still high after 100 cycles.
